// File: rtl/ndp_core_sequencer.sv
// Job sequencer for NDP_core: clears the core, streams A/B operand words from memory, captures the result.
// Optional WAIT-state watchdog enabled by defining NDP_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no job; waits for start
// CLR   | one-cycle core_reset pulse
// LOAD  | issues N_WORDS memory reads back to back
// WAIT  | waits for core_calc_done_flag (watchdog optional)
// DONE  | one-cycle done pulse
module ndp_core_sequencer #(
  parameter int WIDTH          = 16,
  parameter int ARR_HEIGHT     = 4,
  parameter int ARR_WIDTH      = 4,
  parameter int SYS_HEIGHT     = 1,
  parameter int SYS_WIDTH      = 1,
  parameter int K_DEPTH        = 3,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   a_base,
  input  logic [ADDR_W-1:0]   b_base,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH-1:0] result,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [31:0]         mem_rd_data,
  output logic                core_reset,
  output logic                core_data_in_flag,
  output logic [31:0]         core_data_in,
  input  logic                core_calc_done_flag,
  input  logic [SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH-1:0] core_out_c
);

  localparam int AW      = SYS_HEIGHT * ARR_HEIGHT * WIDTH / 32;
  localparam int BW      = SYS_WIDTH * ARR_WIDTH * WIDTH / 32;
  localparam int N_WORDS = K_DEPTH * (AW + BW);
  localparam int RES_W   = SYS_HEIGHT * ARR_HEIGHT * SYS_WIDTH * ARR_WIDTH * WIDTH;
  localparam int SUB_MAX = (AW > BW) ? AW : BW;
  localparam int SUB_W   = $clog2(SUB_MAX + 1);
  localparam int CNT_W   = $clog2(N_WORDS + 1);

  if (AW < 1 || BW < 1 || K_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("ndp_core_sequencer: invalid configuration");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0]   b_ptr_q, b_ptr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic                phase_b_q, phase_b_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                done_q;
  logic [RES_W-1:0]    result_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                flag_q;
  logic                core_reset_q;

`ifdef NDP_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]    tmo_q;
  logic                error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign busy              = (state_q != S_IDLE);
  assign done              = done_q;
  assign result            = result_q;
  assign mem_rd_en         = rd_en_q;
  assign mem_rd_addr       = rd_addr_q;
  assign core_reset        = core_reset_q;
  assign core_data_in_flag = flag_q;
  assign core_data_in      = mem_rd_data;

  // A words of all columns are contiguous, as are B words of all rows, so one
  // running pointer per operand plus a sub-index for the A/B interleave suffices.
  always_comb begin
    a_ptr_d   = a_ptr_q;
    b_ptr_d   = b_ptr_q;
    addr_d    = rd_addr_q;
    phase_b_d = phase_b_q;
    sub_d     = sub_q + SUB_W'(1);
    if (!phase_b_q) begin
      if (sub_q == SUB_W'(AW - 1)) begin
        phase_b_d = 1'b1;
        sub_d     = '0;
        addr_d    = b_ptr_q;
        b_ptr_d   = b_ptr_q + ADDR_W'(1);
      end else begin
        addr_d    = a_ptr_q;
        a_ptr_d   = a_ptr_q + ADDR_W'(1);
      end
    end else begin
      if (sub_q == SUB_W'(BW - 1)) begin
        phase_b_d = 1'b0;
        sub_d     = '0;
        addr_d    = a_ptr_q;
        a_ptr_d   = a_ptr_q + ADDR_W'(1);
      end else begin
        addr_d    = b_ptr_q;
        b_ptr_d   = b_ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      a_ptr_q      <= '0;
      b_ptr_q      <= '0;
      sub_q        <= '0;
      phase_b_q    <= 1'b0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      result_q     <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      flag_q       <= 1'b0;
      core_reset_q <= 1'b1;
`ifdef NDP_SEQ_TIMEOUT_EN
      tmo_q        <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      done_q       <= 1'b0;
      core_reset_q <= 1'b0;
      flag_q       <= rd_en_q;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_ptr_q      <= a_base;
            b_ptr_q      <= b_base;
            core_reset_q <= 1'b1;
            state_q      <= S_CLR;
`ifdef NDP_SEQ_TIMEOUT_EN
            error_q      <= 1'b0;
`endif
          end
        end
        S_CLR: begin
          rd_en_q   <= 1'b1;
          rd_addr_q <= a_ptr_q;
          a_ptr_q   <= a_ptr_q + ADDR_W'(1);
          sub_q     <= '0;
          phase_b_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= S_LOAD;
        end
        S_LOAD: begin
          if (cnt_q == CNT_W'(N_WORDS - 1)) begin
            rd_en_q <= 1'b0;
            state_q <= S_WAIT;
`ifdef NDP_SEQ_TIMEOUT_EN
            tmo_q   <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
          end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
            rd_addr_q <= addr_d;
            a_ptr_q   <= a_ptr_d;
            b_ptr_q   <= b_ptr_d;
            sub_q     <= sub_d;
            phase_b_q <= phase_b_d;
          end
        end
        S_WAIT: begin
          // the core may flag completion while the stream tail is still in flight
          if (core_calc_done_flag && !flag_q) begin
            result_q <= core_out_c;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
`ifdef NDP_SEQ_TIMEOUT_EN
          else if (tmo_q == '0) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q - TMO_W'(1);
          end
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ndp_core_sequencer.sv
// Self-checking bench for ndp_core_sequencer: vector table, random jobs, reset/timeout sequences.
module tb_ndp_core_sequencer;

  localparam int ADDR_W = 10;
  localparam int AW     = 2;
  localparam int BW     = 2;
  localparam int KD     = 3;
  localparam int N      = KD * (AW + BW);
  localparam int RES_W  = 256;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] a_base, b_base;
  logic              busy, done, error;
  logic [RES_W-1:0]  result;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;
  logic              core_reset, core_data_in_flag;
  logic [31:0]       core_data_in;
  logic              core_calc_done_flag;
  logic [RES_W-1:0]  core_out_c;

  int checks = 0;
  int errors = 0;
  logic [RES_W-1:0] last_result;
  logic [ADDR_W-1:0] exp_q[$];

  ndp_core_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .a_base(a_base), .b_base(b_base),
    .busy(busy), .done(done), .error(error), .result(result),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .core_reset(core_reset), .core_data_in_flag(core_data_in_flag),
    .core_data_in(core_data_in), .core_calc_done_flag(core_calc_done_flag),
    .core_out_c(core_out_c)
  );

  always #5 clk = ~clk;

  // memory returns its address as data one cycle after the strobe
  always @(posedge clk) mem_rd_data <= mem_rd_en ? {22'b0, mem_rd_addr} : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_addrs(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    exp_q.delete();
    for (int j = 0; j < KD; j++) begin
      for (int i = 0; i < AW; i++) exp_q.push_back(ADDR_W'((int'(a) + j*AW + i) % 1024));
      for (int i = 0; i < BW; i++) exp_q.push_back(ADDR_W'((int'(b) + j*BW + i) % 1024));
    end
  endtask

  // called #1 after a rising edge; returns at the same phase
  task automatic run_job(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input int delay,
                         input bit glitch, input bit force_early, input logic [RES_W-1:0] outc,
                         input logic [ADDR_W-1:0] exp_a0, input logic [ADDR_W-1:0] exp_a1);
    logic [ADDR_W-1:0] obs_a[$];
    logic [31:0]       obs_d[$];
    int rd_first = -1, rd_last = -1, fl_first = -1, fl_last = -1;
    int fall = -1, calc_cyc = -1, done_cyc = -1, done_cnt = 0, end_cyc = -1;
    bit prev_flag = 1'b0;
    model_addrs(a, b);
    a_base = a; b_base = b; start = 1'b1;
    for (int cyc = 1; cyc <= 300 && end_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      start = glitch && (cyc == 6);
      if (glitch && cyc == 6) begin a_base = ~a; b_base = ~b; end
      if (cyc == 1) begin
        chk("core_reset_in_clr", core_reset, 1);
        chk("error_cleared_on_start", error, 0);
      end
      if (cyc == 2) chk("core_reset_after_clr", core_reset, 0);
      if (mem_rd_en) begin
        obs_a.push_back(mem_rd_addr);
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
      end
      if (core_data_in_flag) begin
        obs_d.push_back(core_data_in);
        if (fl_first < 0) fl_first = cyc;
        fl_last = cyc;
      end
      if (prev_flag && !core_data_in_flag && fall < 0) begin
        fall = cyc;
        chk("no_early_capture", result, last_result);
      end
      prev_flag = core_data_in_flag;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("result_on_done", result, outc);
      end
      if (!busy) end_cyc = cyc;
      core_calc_done_flag = 1'b0;
      core_out_c = ~outc;
      if (force_early && (core_reset || mem_rd_en || core_data_in_flag)) core_calc_done_flag = 1'b1;
      if (fall >= 0 && cyc == fall + delay) begin
        core_calc_done_flag = 1'b1;
        core_out_c = outc;
        calc_cyc = cyc;
      end
    end
    start = 1'b0;
    core_calc_done_flag = 1'b0;
    if (end_cyc < 0) begin
      checks++; errors++;
      $display("FAIL job_budget: job did not return to idle within 300 cycles");
    end
    chk("rd_count", obs_a.size(), N);
    chk("rd_first_cycle", rd_first, 2);
    chk("rd_last_cycle", rd_last, N + 1);
    chk("flag_count", obs_d.size(), N);
    chk("flag_first_cycle", fl_first, 3);
    chk("flag_last_cycle", fl_last, N + 2);
    if (obs_a.size() >= 2) begin
      chk("addr0", obs_a[0], exp_a0);
      chk("addr1", obs_a[1], exp_a1);
    end
    for (int i = 0; i < N && i < obs_a.size(); i++) chk("addr_stream", obs_a[i], exp_q[i]);
    for (int i = 0; i < N && i < obs_d.size(); i++) chk("data_stream", obs_d[i], {22'b0, exp_q[i]});
    chk("done_pulses", done_cnt, 1);
    chk("done_cycle", done_cyc, calc_cyc + 1);
    chk("idle_after_done", end_cyc, done_cyc + 1);
    last_result = outc;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    int                delay;
    bit                glitch;
    bit                force_early;
    logic [RES_W-1:0]  out_c;
    logic [ADDR_W-1:0] exp_a0;
    logic [ADDR_W-1:0] exp_a1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{10'h000, 10'h100, 5, 1'b0, 1'b0, {4{64'h0123_4567_89AB_CDEF}}, 10'h000, 10'h001};
    vecs[1] = '{10'h000, 10'h100, 3, 1'b1, 1'b1, {4{64'hFEDC_BA98_7654_3210}}, 10'h000, 10'h001};
    vecs[2] = '{10'h3FF, 10'h3FE, 1, 1'b0, 1'b0, {8{32'hA5A5_0F0F}},           10'h3FF, 10'h000};
    vecs[3] = '{10'h155, 10'h2AA, 8, 1'b1, 1'b0, {8{32'h1357_9BDF}},           10'h155, 10'h156};

    reset = 1'b1; start = 1'b0; a_base = '0; b_base = '0;
    core_calc_done_flag = 1'b0; core_out_c = '0; last_result = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_result", result, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_flag", core_data_in_flag, 0);
    chk("rst_core_reset", core_reset, 1);
    @(posedge clk); #2 reset = 1'b0;
    chk("core_reset_held_until_edge", core_reset, 1);
    @(posedge clk); #1;
    chk("core_reset_falls", core_reset, 0);

    foreach (vecs[v])
      run_job(vecs[v].a, vecs[v].b, vecs[v].delay, vecs[v].glitch, vecs[v].force_early,
              vecs[v].out_c, vecs[v].exp_a0, vecs[v].exp_a1);

    for (int r = 0; r < 6; r++) begin
      logic [ADDR_W-1:0] ra, rb;
      logic [RES_W-1:0]  rc;
      ra = ADDR_W'($urandom_range(0, 1023));
      rb = ADDR_W'($urandom_range(0, 1023));
      for (int w = 0; w < 8; w++) rc[w*32 +: 32] = $urandom();
      run_job(ra, rb, int'($urandom_range(1, 10)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), rc, ra, ra + ADDR_W'(1));
    end

    // reset during LOAD aborts the job
    begin
      int dn = 0;
      a_base = 10'h000; b_base = 10'h100; start = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      chk("mid_load_rd_en", mem_rd_en, 1);
      #2 reset = 1'b1;
      core_calc_done_flag = 1'b1; core_out_c = {8{32'h5555_AAAA}};
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_error", error, 0);
      chk("abort_result", result, 0);
      chk("abort_rd_en", mem_rd_en, 0);
      chk("abort_rd_addr", mem_rd_addr, 0);
      chk("abort_flag", core_data_in_flag, 0);
      chk("abort_core_reset", core_reset, 1);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(posedge clk); #1;
      chk("abort_core_reset_falls", core_reset, 0);
      for (int cyc = 0; cyc < 25; cyc++) begin
        core_calc_done_flag = bit'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (done) dn++;
      end
      core_calc_done_flag = 1'b0;
      chk("abort_no_done", dn, 0);
      chk("abort_result_held", result, 0);
      last_result = '0;
    end

`ifdef NDP_SEQ_TIMEOUT_EN
    begin
      int rise = -1, dn = 0;
      a_base = 10'h010; b_base = 10'h200; start = 1'b1;
      for (int cyc = 1; cyc <= 100 && rise < 0; cyc++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (done) dn++;
        if (error) rise = cyc;
      end
      chk("timeout_cycle", rise, 2 + N + TMO);
      chk("timeout_busy", busy, 0);
      chk("timeout_result", result, last_result);
      chk("timeout_no_done", dn, 0);
      run_job(10'h020, 10'h220, 4, 1'b0, 1'b0, {8{32'hC0DE_F00D}}, 10'h020, 10'h021);
    end
`else
    begin
      int dn = 0, err_seen = 0;
      a_base = 10'h010; b_base = 10'h200; start = 1'b1;
      for (int cyc = 1; cyc <= 80; cyc++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (done) dn++;
        if (error) err_seen++;
      end
      chk("wait_forever_busy", busy, 1);
      chk("wait_forever_error", err_seen, 0);
      chk("wait_forever_no_done", dn, 0);
      core_calc_done_flag = 1'b1; core_out_c = {8{32'hC0DE_F00D}};
      @(posedge clk); #1;
      core_calc_done_flag = 1'b0;
      chk("late_done", done, 1);
      chk("late_result", result, {8{32'hC0DE_F00D}});
      @(posedge clk); #1;
      chk("late_done_one_cycle", done, 0);
      chk("late_idle", busy, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
